ram_stream_reader: RTL and testbench

//   Read-side initiator for the single-port sync RAM (1-cycle registered read, rd_en-gated dout).

---
 rtl/ram_stream_reader.sv | 132 +++++++++++++
 tb/tb_ram_stream_reader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Streams a contiguous RAM window out as valid/ready beats.
// A 2-entry buffer absorbs the RAM's fixed 1-cycle read latency.
module ram_stream_reader #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  issued;
  logic [LEN_WIDTH-1:0]  sent;
  logic [LEN_WIDTH-1:0]  len_m1;
  logic                  inflight;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] ent0;
  logic [DATA_WIDTH-1:0] ent1;
  logic                  pop;
  logic                  push;
  logic                  credit;
  logic                  issue;

  assign len_m1  = len_q - LEN_WIDTH'(1);
  assign m_valid = (occ != 2'd0);
  assign m_data  = ent0;
  assign m_last  = m_valid && (sent == len_m1);
  assign pop     = m_valid & m_ready;
  assign push    = inflight;

  // A pop this cycle frees a slot, so it counts toward the credit.
  assign credit = ({1'b0, occ} + {2'b00, inflight})
                < (3'd2 + {2'b00, pop});

  assign issue = (state == S_RUN)
              && (issued != len_q)
              && credit;

  assign ram_rd_en = issue;
  assign ram_addr  = issue
                   ? base_q + ADDR_WIDTH'(issued)
                   : '0;

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      sent     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) issued <= issued + LEN_WIDTH'(1);
      if (pop)   sent   <= sent + LEN_WIDTH'(1);
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= len;
            issued <= '0;
            sent   <= '0;
            state  <= (len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issue && issued == len_m1)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && sent == len_m1)
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= ram_dout;
          else             ent1 <= ram_dout;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            ent0 <= ent1;
            ent1 <= ram_dout;
          end else begin
            ent0 <= ram_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: vector table, hand sequences and
// random transfers checked against a simple word-list model.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [12:0] len = '0;
  logic        busy, done, ram_rd_en;
  logic [11:0] ram_addr;
  logic [63:0] ram_dout = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [63:0] m_data;
  logic        m_last;

  logic [63:0] mem [4096];
  int checks = 0;
  int failures = 0;

  ram_stream_reader dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .len(len),
    .busy(busy), .done(done),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
    .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_rd_en) ram_dout <= mem[ram_addr];

  typedef struct {
    logic [11:0] base;
    int          n;
    int          mode;
    int          exp_done;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic pick(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 4 == 0) || (c % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_rd_en"}, 64'(ram_rd_en), 0);
    chk({tag, "_addr"}, 64'(ram_addr), 0);
    chk({tag, "_valid"}, 64'(m_valid), 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_last"}, 64'(m_last), 0);
  endtask

  task automatic run_xfer(input logic [11:0] base, input int n,
                          input int mode, input int exp_done,
                          input int abort_at, input bit repoke);
    int cyc = 0, beats = 0, reads = 0;
    int last_cyc = -1, done_cyc = -1;
    bit stalled = 0, any_valid = 0;
    logic [63:0] hold = '0;
    logic [11:0] a;
    @(negedge clk);
    start = 1'b1; base_addr = base; len = 13'(n); m_ready = 1'b0;
    @(negedge clk);
    while (done_cyc < 0 && cyc < 400) begin
      start = 1'b0;
      base_addr = 12'($urandom); len = 13'($urandom);
      if (repoke && cyc == 3) begin
        start = 1'b1; base_addr = 12'h300; len = 13'd7;
      end
      m_ready = pick(mode, cyc);
      #1;
      if (cyc == 0) chk("busy_start", 64'(busy), 64'(n != 0));
      if (ram_rd_en) begin
        a = base + 12'(reads);
        chk("rd_addr", 64'(ram_addr), 64'(a));
        reads++;
      end
      if (m_valid) any_valid = 1;
      if (stalled) begin
        chk("stall_valid", 64'(m_valid), 1);
        chk("stall_data", m_data, hold);
      end
      if (m_valid && m_ready) begin
        a = base + 12'(beats);
        chk("beat_data", m_data, mem[a]);
        chk("beat_last", 64'(m_last), 64'(beats == n - 1));
        beats++;
        last_cyc = cyc;
      end
      chk("ahead", 64'((reads - beats) <= 2), 1);
      if (done) begin
        done_cyc = cyc;
        chk("busy_at_done", 64'(busy), 0);
      end
      stalled = m_valid && !m_ready;
      hold = m_data;
      if (abort_at >= 0 && beats == abort_at) break;
      @(negedge clk);
      cyc++;
    end
    if (abort_at >= 0) begin
      chk("abort_reached", 64'(beats), 64'(abort_at));
      chk("abort_no_done", 64'(done_cyc < 0), 1);
      @(negedge clk);
      rst = 1'b1; start = 1'b0; m_ready = pick(2, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_zero("abort");
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        #1;
        chk("abort_quiet", 64'(done | m_valid | ram_rd_en), 0);
      end
      return;
    end
    chk("done_seen", 64'(done_cyc >= 0), 1);
    chk("beat_count", 64'(beats), 64'(n));
    chk("read_count", 64'(reads), 64'(n));
    if (n == 0) chk("len0_valid", 64'(any_valid), 0);
    else chk("done_after_last", 64'(done_cyc), 64'(last_cyc + 1));
    if (exp_done >= 0) chk("done_cycle", 64'(done_cyc), 64'(exp_done));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 64'(i);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero("reset");

    vecs.push_back('{12'h010, 4, 0, 6});
    vecs.push_back('{12'h010, 4, 1, -1});
    vecs.push_back('{12'hFFE, 4, 0, 6});
    vecs.push_back('{12'h000, 0, 0, 0});
    vecs.push_back('{12'h100, 1, 0, 3});
    vecs.push_back('{12'h200, 9, 2, -1});
    vecs.push_back('{12'hFFF, 2, 1, -1});
    foreach (vecs[i])
      run_xfer(vecs[i].base, vecs[i].n, vecs[i].mode,
               vecs[i].exp_done, -1, 1'b0);

    run_xfer(12'h040, 8, 0, -1, 2, 1'b0);
    run_xfer(12'h040, 8, 0, 10, -1, 1'b0);
    run_xfer(12'h080, 6, 1, -1, -1, 1'b1);
    run_xfer(12'h0C0, 6, 0, 8, -1, 1'b1);

    for (int i = 0; i < 4096; i++)
      mem[i] = {$urandom, $urandom};
    for (int t = 0; t < 25; t++) begin
      int n = $urandom_range(0, 40);
      int mode = $urandom_range(0, 2);
      int ed = (mode == 0) ? ((n == 0) ? 0 : n + 2) : -1;
      run_xfer(12'($urandom), n, mode, ed, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
